// File: rtl/light_sensor_sample_sequencer.sv
// light_sensor_sample_sequencer: paces SPI light-sensor conversions,
// validates returned frames and box-car averages the light readings.
module light_sensor_sample_sequencer #(
    parameter int SAMPLE_PERIOD = 1000,
    parameter int RX_TIMEOUT    = 200,
    parameter int LOG2_AVG      = 3
) (
    input  logic        i_Clk,
    input  logic        i_RST_L,
    input  logic        i_Enable,
    input  logic        i_TX_Ready,
    output logic        o_TX_DV,
    input  logic        i_RX_DV,
    input  logic [15:0] i_RX_Word,
    output logic [7:0]  o_Sample,
    output logic        o_Sample_DV,
    output logic [7:0]  o_Avg,
    output logic        o_Avg_DV,
    output logic        o_Frame_Err,
    output logic        o_Timeout,
    output logic        o_Missed
);
    localparam int PW    = $clog2(SAMPLE_PERIOD);
    localparam int TW    = $clog2(RX_TIMEOUT);
    localparam int ACC_W = 8 + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;

    localparam logic [PW-1:0]    PER_LAST = PW'(SAMPLE_PERIOD - 1);
    localparam logic [TW-1:0]    TO_LAST  = TW'(RX_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << LOG2_AVG) - 1);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] WAIT_RX = 1'b1;

    logic [0:0]       state;
    logic [PW-1:0]    per_cnt;
    logic [TW-1:0]    to_cnt;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             pending;

    logic             tick;
    logic             issue;
    logic             got_frame;
    logic             frame_ok;
    logic             last_sample;
    logic [7:0]       rx_data;
    logic [ACC_W-1:0] acc_sum;

    assign tick        = i_Enable && (per_cnt == PER_LAST);
    assign issue       = (state == IDLE) && (pending || tick) && i_TX_Ready;
    assign got_frame   = (state == WAIT_RX) && i_RX_DV;
    assign frame_ok    = (i_RX_Word[15:12] == 4'h0) && (i_RX_Word[3:0] == 4'h0);
    assign rx_data     = i_RX_Word[11:4];
    assign acc_sum     = acc + ACC_W'(rx_data);
    assign last_sample = (cnt == CNT_LAST);

    always_ff @(posedge i_Clk) begin
        if (!i_RST_L) begin
            state       <= IDLE;
            per_cnt     <= '0;
            to_cnt      <= '0;
            acc         <= '0;
            cnt         <= '0;
            pending     <= 1'b0;
            o_TX_DV     <= 1'b0;
            o_Sample    <= '0;
            o_Sample_DV <= 1'b0;
            o_Avg       <= '0;
            o_Avg_DV    <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Timeout   <= 1'b0;
            o_Missed    <= 1'b0;
        end else begin
            o_TX_DV     <= 1'b0;
            o_Sample_DV <= 1'b0;
            o_Avg_DV    <= 1'b0;
            o_Frame_Err <= 1'b0;
            o_Timeout   <= 1'b0;

            if (!i_Enable || tick) per_cnt <= '0;
            else                   per_cnt <= per_cnt + PW'(1);

            if (tick && pending) o_Missed <= 1'b1;

            // a tick coinciding with an issue leaves one request still owed
            if (!i_Enable)  pending <= 1'b0;
            else if (issue) pending <= pending && tick;
            else if (tick)  pending <= 1'b1;

            case (state)
                IDLE: begin
                    if (issue) begin
                        o_TX_DV <= 1'b1;
                        to_cnt  <= '0;
                        state   <= WAIT_RX;
                    end
                end
                WAIT_RX: begin
                    to_cnt <= to_cnt + TW'(1);
                    if (i_RX_DV) begin
                        state <= IDLE;
                    end else if (to_cnt == TO_LAST) begin
                        o_Timeout <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (got_frame) begin
                if (frame_ok) begin
                    o_Sample    <= rx_data;
                    o_Sample_DV <= 1'b1;
                end else begin
                    o_Frame_Err <= 1'b1;
                end
            end

            if (!i_Enable) begin
                acc <= '0;
                cnt <= '0;
            end else if (got_frame && frame_ok) begin
                if (last_sample) begin
                    o_Avg    <= 8'(acc_sum >> LOG2_AVG);
                    o_Avg_DV <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= acc_sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_light_sensor_sample_sequencer.sv
// tb_light_sensor_sample_sequencer: directed tables, corner sequences
// and randomized transactions against an arithmetic reference model.
`timescale 1ns/1ps
module tb_light_sensor_sample_sequencer;
    localparam int SP = 20;
    localparam int RT = 15;
    localparam int LA = 3;

    logic        i_Clk = 1'b0;
    logic        i_RST_L;
    logic        i_Enable;
    logic        i_TX_Ready;
    logic        o_TX_DV;
    logic        i_RX_DV;
    logic [15:0] i_RX_Word;
    logic [7:0]  o_Sample;
    logic        o_Sample_DV;
    logic [7:0]  o_Avg;
    logic        o_Avg_DV;
    logic        o_Frame_Err;
    logic        o_Timeout;
    logic        o_Missed;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] word;
        logic        sdv;
        logic [7:0]  smp;
        logic        adv;
        logic [7:0]  avg;
        logic        ferr;
    } vec_t;

    vec_t tbl[$];

    always #5 i_Clk = ~i_Clk;

    light_sensor_sample_sequencer #(
        .SAMPLE_PERIOD(SP),
        .RX_TIMEOUT(RT),
        .LOG2_AVG(LA)
    ) dut (
        .i_Clk(i_Clk),
        .i_RST_L(i_RST_L),
        .i_Enable(i_Enable),
        .i_TX_Ready(i_TX_Ready),
        .o_TX_DV(o_TX_DV),
        .i_RX_DV(i_RX_DV),
        .i_RX_Word(i_RX_Word),
        .o_Sample(o_Sample),
        .o_Sample_DV(o_Sample_DV),
        .o_Avg(o_Avg),
        .o_Avg_DV(o_Avg_DV),
        .o_Frame_Err(o_Frame_Err),
        .o_Timeout(o_Timeout),
        .o_Missed(o_Missed)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", nm, act, exp);
        end
    endtask

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(negedge i_Clk);
        cyc++;
    endtask

    task automatic wait_tx(input int budget);
        int ok;
        ok = 0;
        for (int i = 0; i < budget && ok == 0; i++) begin
            step();
            if (o_TX_DV) ok = 1;
        end
        chki("tx_wait", ok, 1);
    endtask

    task automatic do_reset(input int n);
        i_RST_L = 1'b0;
        repeat (n) step();
        i_RST_L = 1'b1;
    endtask

    task automatic send(input logic [15:0] w);
        i_RX_DV   = 1'b1;
        i_RX_Word = w;
        step();
        i_RX_DV   = 1'b0;
        i_RX_Word = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t v;
        int last_tx, t0, any, k, d, to_at, sdv_n, ferr_n, adv_n;
        int m_n, m_sum, valid, accept, exp_adv;
        logic [7:0] m_smp, m_avg, data;
        logic [15:0] w;

        for (int i = 1; i <= 8; i++) begin
            v.word = 16'((i * 10) << 4);
            v.sdv  = 1'b1;
            v.smp  = 8'(i * 10);
            v.adv  = (i == 8);
            v.avg  = (i == 8) ? 8'd45 : 8'd0;
            v.ferr = 1'b0;
            tbl.push_back(v);
        end
        tbl.push_back('{16'h0640, 1'b1, 8'd100, 1'b0, 8'd45, 1'b0});
        tbl.push_back('{16'h10A0, 1'b0, 8'd100, 1'b0, 8'd45, 1'b1});
        tbl.push_back('{16'h00A1, 1'b0, 8'd100, 1'b0, 8'd45, 1'b1});
        for (int i = 1; i <= 7; i++) begin
            v.word = 16'h0320;
            v.sdv  = 1'b1;
            v.smp  = 8'd50;
            v.adv  = (i == 7);
            v.avg  = (i == 7) ? 8'd56 : 8'd45;
            v.ferr = 1'b0;
            tbl.push_back(v);
        end

        i_RST_L    = 1'b0;
        i_Enable   = 1'b1;
        i_TX_Ready = 1'b1;
        i_RX_DV    = 1'b0;
        i_RX_Word  = '0;

        // reset holds every output low
        do_reset(5);
        i_RST_L = 1'b0;
        chk1("rst_tx_dv", o_TX_DV, 1'b0);
        chk8("rst_sample", o_Sample, 8'd0);
        chk1("rst_sample_dv", o_Sample_DV, 1'b0);
        chk8("rst_avg", o_Avg, 8'd0);
        chk1("rst_avg_dv", o_Avg_DV, 1'b0);
        chk1("rst_frame_err", o_Frame_Err, 1'b0);
        chk1("rst_timeout", o_Timeout, 1'b0);
        chk1("rst_missed", o_Missed, 1'b0);

        i_RST_L  = 1'b1;
        i_Enable = 1'b0;
        any = 0;
        repeat (3000) begin
            step();
            if (o_TX_DV) any++;
        end
        chki("disabled_tx_count", any, 0);

        // periodic requests with table-driven frames
        i_Enable = 1'b1;
        last_tx  = -1;
        foreach (tbl[i]) begin
            wait_tx(40);
            if (last_tx >= 0) chki("tx_period", cyc - last_tx, SP);
            last_tx = cyc;
            step();
            chk1("tx_width", o_TX_DV, 1'b0);
            repeat (8) step();
            send(tbl[i].word);
            chk1("tbl_sample_dv", o_Sample_DV, tbl[i].sdv);
            chk8("tbl_sample", o_Sample, tbl[i].smp);
            chk1("tbl_avg_dv", o_Avg_DV, tbl[i].adv);
            chk8("tbl_avg", o_Avg, tbl[i].avg);
            chk1("tbl_frame_err", o_Frame_Err, tbl[i].ferr);
            chk1("tbl_timeout", o_Timeout, 1'b0);
        end
        chk1("tbl_missed", o_Missed, 1'b0);

        // unanswered request times out, next tick requests again
        wait_tx(40);
        t0 = cyc;
        k  = 0;
        while (!o_Timeout && k < 30) begin
            step();
            k++;
        end
        chki("timeout_delay", cyc - t0, RT);
        step();
        chk1("timeout_width", o_Timeout, 1'b0);
        wait_tx(30);
        chki("tx_after_timeout", cyc - t0, SP);

        // frame arriving on the timeout cycle wins
        repeat (RT - 1) step();
        send(16'h0770);
        chk1("coll_sample_dv", o_Sample_DV, 1'b1);
        chk8("coll_sample", o_Sample, 8'd119);
        chk1("coll_timeout", o_Timeout, 1'b0);
        any = 0;
        repeat (4) begin
            step();
            if (o_Timeout) any++;
        end
        chki("coll_no_late_timeout", any, 0);

        // enable drops mid-transaction: sample shown, not accumulated
        wait_tx(40);
        i_Enable = 1'b0;
        repeat (4) step();
        send(16'h0100);
        chk1("endrop_sample_dv", o_Sample_DV, 1'b1);
        chk8("endrop_sample", o_Sample, 8'd16);
        chk1("endrop_avg_dv", o_Avg_DV, 1'b0);
        i_Enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_tx(40);
            repeat (5) step();
            send(16'h0080);
            chk1("fresh_avg_dv", o_Avg_DV, (i == 7));
        end
        chk8("fresh_avg", o_Avg, 8'd8);

        // backpressure: requests owed, a missed period
        i_TX_Ready = 1'b0;
        do_reset(2);
        any = 0;
        repeat (50) begin
            step();
            if (o_TX_DV) any++;
        end
        chki("bp_no_tx", any, 0);
        chk1("bp_missed", o_Missed, 1'b1);
        i_TX_Ready = 1'b1;
        step();
        chk1("bp_tx_next", o_TX_DV, 1'b1);
        step();
        chk1("bp_tx_single", o_TX_DV, 1'b0);
        chk1("bp_missed_sticky", o_Missed, 1'b1);

        // reset mid-transaction, later frame ignored
        wait_tx(40);
        repeat (2) step();
        do_reset(2);
        send(16'h0550);
        chk1("midrst_sample_dv", o_Sample_DV, 1'b0);
        chk8("midrst_sample", o_Sample, 8'd0);
        chk1("midrst_missed", o_Missed, 1'b0);

        // randomized transactions versus arithmetic model
        m_n   = 0;
        m_sum = 0;
        m_smp = '0;
        m_avg = '0;
        for (int t = 0; t < 60; t++) begin
            wait_tx(40);
            d     = $urandom_range(0, RT + 2);
            data  = 8'($urandom);
            valid = ($urandom_range(0, 3) != 0) ? 1 : 0;
            w     = {4'h0, data, 4'h0};
            if (valid == 0) begin
                if ($urandom_range(0, 1) == 1) w[15:12] = 4'($urandom_range(1, 15));
                else                           w[3:0]   = 4'($urandom_range(1, 15));
            end
            accept = (d <= RT - 1) ? 1 : 0;
            to_at  = -1;
            sdv_n  = 0;
            ferr_n = 0;
            adv_n  = 0;
            if (d == 0) begin
                i_RX_DV   = 1'b1;
                i_RX_Word = w;
            end
            for (int j = 1; j <= RT + 3; j++) begin
                step();
                i_RX_DV   = 1'b0;
                i_RX_Word = '0;
                if (o_Timeout)   to_at = j;
                if (o_Sample_DV) sdv_n++;
                if (o_Frame_Err) ferr_n++;
                if (o_Avg_DV)    adv_n++;
                if (j == d) begin
                    i_RX_DV   = 1'b1;
                    i_RX_Word = w;
                end
            end
            exp_adv = 0;
            if (accept == 1 && valid == 1) begin
                m_smp = data;
                m_n++;
                m_sum += int'(data);
                if (m_n == (1 << LA)) begin
                    m_avg   = 8'(m_sum / (1 << LA));
                    exp_adv = 1;
                    m_n     = 0;
                    m_sum   = 0;
                end
            end
            chki("rnd_timeout_at", to_at, (accept == 1) ? -1 : RT);
            chki("rnd_sample_dv", sdv_n, accept & valid);
            chki("rnd_frame_err", ferr_n, accept & (1 - valid));
            chki("rnd_avg_dv", adv_n, exp_adv);
            chk8("rnd_sample", o_Sample, m_smp);
            chk8("rnd_avg", o_Avg, m_avg);
        end
        chk1("rnd_missed", o_Missed, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/light_sensor_sample_sequencer.md
Name: light_sensor_sample_sequencer

Overview:
- Control and data stage around the light-sensor SPI master. It paces conversions with a periodic request pulse on the master's `i_TX_DV`.
- It consumes the 16-bit frame the master shifts in, checks the frame format and extracts the 8-bit light reading.
- It box-car averages 2^LOG2_AVG valid readings into one averaged output.
- Upstream of the master for requests; downstream of it for received data.

Parameters:
- SAMPLE_PERIOD, 1000, i_Clk cycles between conversion requests (>=2).
- RX_TIMEOUT, 200, i_Clk cycles allowed from request to frame return (>=2).
- LOG2_AVG, 3, log2 of samples per average (0..6; 3 = 8 samples).

Ports:
- i_Clk  in  1  system clock; all logic on posedge.
- i_RST_L  in  1  synchronous, active-low reset.
- i_Enable  in  1  high = run periodic sampling.
- i_TX_Ready  in  1  SPI master idle and able to accept a request.
- o_TX_DV  out  1  one-cycle request pulse to the SPI master.
- i_RX_DV  in  1  one-cycle strobe: i_RX_Word is valid.
- i_RX_Word  in  16  raw frame: [15:12]=0, [11:4]=light data, [3:0]=0.
- o_Sample  out  8  last valid light reading.
- o_Sample_DV  out  1  one-cycle strobe when o_Sample updates.
- o_Avg  out  8  averaged light reading.
- o_Avg_DV  out  1  one-cycle strobe when o_Avg updates.
- o_Frame_Err  out  1  one-cycle pulse: received frame had nonzero pad bits.
- o_Timeout  out  1  one-cycle pulse: no frame within RX_TIMEOUT.
- o_Missed  out  1  sticky: a period elapsed while a request was still pending; cleared only by reset.

Behaviour:
- Reset (i_RST_L low at posedge): all outputs 0; state IDLE; period counter, timeout counter, accumulator, sample count and pending flag all 0.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 while i_Enable=1, then wraps.
  - The cycle it equals SAMPLE_PERIOD-1 is "tick"; tick sets pending.
  - Tick while pending is already 1 sets o_Missed.
  - i_Enable=0 holds the counter, pending, accumulator and sample count at 0.
- FSM states: IDLE, WAIT_RX.
- IDLE:
  - If pending=1 and i_TX_Ready=1: assert o_TX_DV for exactly one cycle, clear pending, load the timeout counter with 0, go to WAIT_RX.
  - i_RX_DV in IDLE is ignored; no outputs change.
- WAIT_RX:
  - The timeout counter increments each cycle.
  - If i_RX_DV=1: go to IDLE and process the frame (below).
  - Else if the counter = RX_TIMEOUT-1: pulse o_Timeout one cycle and go to IDLE. No retry; the next tick issues the next request.
  - i_RX_DV and timeout in the same cycle: the frame wins and there is no o_Timeout.
  - o_TX_DV is never asserted in WAIT_RX. A tick during WAIT_RX only sets pending.
- Frame processing (registered; outputs valid the cycle after i_RX_DV):
  - Valid frame (i_RX_Word[15:12]=0 and i_RX_Word[3:0]=0):
    - o_Sample <= i_RX_Word[11:4]; o_Sample_DV pulses.
    - accumulator += sample; count += 1.
  - Invalid frame: o_Frame_Err pulses. No sample, accumulator or count update.
- Averaging:
  - Accumulator width is 8+LOG2_AVG bits; no overflow is possible.
  - When the accumulated sample is the 2^LOG2_AVG-th:
    - o_Avg <= (accumulator + sample) >> LOG2_AVG, truncated.
    - o_Avg_DV pulses in the same cycle as that sample's o_Sample_DV.
    - Accumulator and count reset to 0.
  - LOG2_AVG=0: o_Avg equals every sample, and o_Avg_DV coincides with every o_Sample_DV.
- i_Enable falling during WAIT_RX:
  - The in-flight transaction completes or times out normally.
  - A returned valid frame updates o_Sample / o_Sample_DV but is not accumulated.
- Reset mid-transaction: return to IDLE immediately. Any later i_RX_DV is ignored, since the FSM is in IDLE.
- Request latency: o_TX_DV asserts on the cycle after tick when i_TX_Ready=1. Otherwise it asserts on the first cycle after tick in which i_TX_Ready=1 is sampled in IDLE.

Test Plan:
- Reset and idle: hold i_RST_L=0 for 5 cycles with i_Enable=1 -> all outputs 0; release, i_Enable=0 for 3000 cycles -> no o_TX_DV.
- Periodic request: SAMPLE_PERIOD=20, i_Enable=1, i_TX_Ready=1, respond with i_RX_DV 10 cycles after each request -> o_TX_DV every 20 cycles, exactly one cycle wide.
- Averaging: LOG2_AVG=3, eight frames with data 10,20,...,80 (words 0x00A0..0x0500) -> eight o_Sample_DV pulses; o_Avg=45 (360>>3) with o_Avg_DV coincident with the 8th o_Sample_DV; a following frame of 100 does not pulse o_Avg_DV.
- Frame error: i_RX_Word=0x10A0, then 0x00A1 -> two o_Frame_Err pulses; o_Sample unchanged; sample count unchanged.
- Timeout and collision:
  - No i_RX_DV after a request -> o_Timeout exactly RX_TIMEOUT cycles after o_TX_DV; FSM back in IDLE.
  - i_RX_DV on the timeout cycle -> sample accepted and no o_Timeout.
- Backpressure/missed: hold i_TX_Ready=0 for 2.5 periods -> no o_TX_DV and o_Missed=1 (sticky); raise i_TX_Ready -> one o_TX_DV next cycle.
